// File: rtl/cska_pkg.sv
// -----------------------------------------------------------------------------
// cska_pkg
// Shared definitions for the byte-serial carry-skip adder sequencer:
//   BYTE_W  - width of one adder lane (the cska8b datapath width)
//   state_t - sequencer state encoding; 2'd3 is unused and recovers to IDLE
// -----------------------------------------------------------------------------
package cska_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/cska8b.sv
// -----------------------------------------------------------------------------
// cska8b
// Purely combinational 8-bit carry-skip adder built from two 4-bit ripple
// blocks. When every bit of a block propagates, the block carry-out is taken
// straight from the block carry-in, bypassing the ripple chain.
// Ports:
//   a, b - 8-bit operands
//   cin  - carry into bit 0
//   sum  - 8-bit sum
//   cout - carry out of bit 7
// -----------------------------------------------------------------------------
module cska8b (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);

   localparam int unsigned BLK_W  = 4;
   localparam int unsigned N_BLKS = 2;

   logic [7:0]        p;
   logic [7:0]        g;
   logic [N_BLKS:0]   blk_c;
   logic              c;

   always_comb begin
      p     = a ^ b;
      g     = a & b;
      sum   = '0;
      c     = cin;
      blk_c = '0;
      blk_c[0] = cin;
      for (int unsigned blk = 0; blk < N_BLKS; blk++) begin
         c = blk_c[blk];
         for (int unsigned i = 0; i < BLK_W; i++) begin
            sum[blk*BLK_W + i] = p[blk*BLK_W + i] ^ c;
            c = g[blk*BLK_W + i] | (p[blk*BLK_W + i] & c);
         end
         // Skip path: an all-propagate block passes its carry-in through.
         blk_c[blk+1] = (&p[blk*BLK_W +: BLK_W]) ? blk_c[blk] : c;
      end
      cout = blk_c[N_BLKS];
   end

endmodule

// File: rtl/cska_seq_adder.sv
// -----------------------------------------------------------------------------
// cska_seq_adder
// Wide adder that time-shares a single cska8b across NBYTES byte lanes,
// least-significant byte first, chaining the carry through a register.
// One operation takes NBYTES RUN cycles followed by a one-cycle DONE; a start
// seen in DONE launches the next operation with no IDLE gap.
//
// Parameters:
//   NBYTES - number of 8-bit lanes (>= 1); operand width W = 8*NBYTES
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   start - request, accepted only in IDLE or DONE
//   a, b  - W-bit operands, latched on the accept edge
//   cin   - carry into byte 0, latched on the accept edge
//   sub   - (only with CSKA_SEQ_SUB_EN) compute a - b instead of a + b + cin
//   busy  - high while in RUN
//   done  - one-cycle pulse in DONE
//   sum   - W-bit result, valid from done until the next accept
//   cout  - carry out of the top byte (no-borrow flag in subtract mode)
//   zero  - sum == 0, same validity as sum
//
// Configuration macro:
//   CSKA_SEQ_SUB_EN - when defined, adds the sub input for a - b mod 2^W.
// -----------------------------------------------------------------------------
module cska_seq_adder
   import cska_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [BYTE_W*NBYTES-1:0] a,
   input  logic [BYTE_W*NBYTES-1:0] b,
   input  logic                   cin,
`ifdef CSKA_SEQ_SUB_EN
   input  logic                   sub,
`endif
   output logic                   busy,
   output logic                   done,
   output logic [BYTE_W*NBYTES-1:0] sum,
   output logic                   cout,
   output logic                   zero
);

   localparam int W     = BYTE_W * NBYTES;
   localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q,   idx_d;
   logic [W-1:0]       a_q,     a_d;
   logic [W-1:0]       b_q,     b_d;
   logic [W-1:0]       sum_q,   sum_d;
   logic               carry_q, carry_d;
   logic               cout_q,  cout_d;
   logic               zero_q,  zero_d;

   logic [BYTE_W-1:0]  add_sum;
   logic               add_cout;
   logic [W-1:0]       sum_next;
   logic [W-1:0]       b_load;
   logic               c_load;
   logic               accept;
   logic               last;

   // Operand conditioning applied on the accept edge.
`ifdef CSKA_SEQ_SUB_EN
   always_comb begin
      b_load = sub ? ~b : b;
      c_load = sub ? 1'b1 : cin;
   end
`else
   always_comb begin
      b_load = b;
      c_load = cin;
   end
`endif

   cska8b u_add (
      .a    (a_q[BYTE_W-1:0]),
      .b    (b_q[BYTE_W-1:0]),
      .cin  (carry_q),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // New byte enters at the top; after NBYTES passes byte 0 has reached the
   // bottom. With a single lane the shift collapses to a direct load.
   generate
      if (NBYTES == 1) begin : g_one_lane
         always_comb sum_next = add_sum;
      end else begin : g_multi_lane
         always_comb sum_next = {add_sum, sum_q[W-1:BYTE_W]};
      end
   endgenerate

   always_comb begin
      accept = start && ((state_q == IDLE) || (state_q == DONE));
      last   = (idx_q == IDX_W'(NBYTES - 1));
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      zero_d  = zero_q;

      case (state_q)
         IDLE: begin
            if (start) state_d = RUN;
         end
         RUN: begin
            a_d     = a_q >> BYTE_W;
            b_d     = b_q >> BYTE_W;
            sum_d   = sum_next;
            carry_d = add_cout;
            idx_d   = idx_q + 1'b1;
            if (last) begin
               state_d = DONE;
               cout_d  = add_cout;
               zero_d  = (sum_next == '0);
            end
         end
         DONE: begin
            state_d = start ? RUN : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Accept overrides the held operand/carry registers; sum and cout keep
      // their previous values until the run overwrites them.
      if (accept) begin
         a_d     = a;
         b_d     = b_load;
         carry_d = c_load;
         idx_d   = '0;
         zero_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         zero_q  <= zero_d;
      end
   end

   always_comb begin
      busy = (state_q == RUN);
      done = (state_q == DONE);
      sum  = sum_q;
      cout = cout_q;
      zero = zero_q;
   end

endmodule

// File: tb/tb_cska_seq_adder.sv
// -----------------------------------------------------------------------------
// tb_cska_seq_adder
// Bench for cska_seq_adder: a 4-lane instance checked every cycle against a
// transaction-level model (result = a + b + cin computed in one step, ready
// NBYTES cycles after accept), plus a 1-lane instance checked per operation.
// Honours CSKA_SEQ_SUB_EN when defined.
// -----------------------------------------------------------------------------
module tb_cska_seq_adder;

   localparam int NB = 4;
   localparam int W  = 8 * NB;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [W-1:0]  a, b;
   logic          cin;
   logic          sub;
   logic          busy, done, cout, zero;
   logic [W-1:0]  sum;

   logic          start1;
   logic [7:0]    a1, b1, sum1;
   logic          cin1, busy1, done1, cout1, zero1;

   int tests = 0;
   int fails = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   cska_seq_adder #(.NBYTES(NB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef CSKA_SEQ_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .zero  (zero)
   );

   cska_seq_adder #(.NBYTES(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start1),
      .a     (a1),
      .b     (b1),
      .cin   (cin1),
`ifdef CSKA_SEQ_SUB_EN
      .sub   (1'b0),
`endif
      .busy  (busy1),
      .done  (done1),
      .sum   (sum1),
      .cout  (cout1),
      .zero  (zero1)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: remaining RUN cycles, done flag, held results.
   int           m_run  = 0;
   bit           m_done = 1'b0;
   logic [W-1:0] m_sum  = '0;
   logic         m_cout = 1'b0;
   logic         m_zero = 1'b0;
   logic [W:0]   m_pend = '0;
   logic [W:0]   m_bb;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run  = 0;
         m_done = 1'b0;
         m_sum  = '0;
         m_cout = 1'b0;
         m_zero = 1'b0;
      end else if (m_run == 0 && start) begin
         m_bb   = {1'b0, (sub ? ~b : b)};
         m_pend = {1'b0, a} + m_bb + {{W{1'b0}}, (sub ? 1'b1 : cin)};
         m_run  = NB;
         m_done = 1'b0;
         m_zero = 1'b0;
      end else if (m_run > 0) begin
         m_run--;
         if (m_run == 0) begin
            m_done = 1'b1;
            m_sum  = m_pend[W-1:0];
            m_cout = m_pend[W];
            m_zero = (m_pend[W-1:0] == '0);
         end
      end else begin
         m_done = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("busy", {63'd0, busy}, {63'd0, (m_run > 0)});
         chk("done", {63'd0, done}, {63'd0, m_done});
         chk("cout", {63'd0, cout}, {63'd0, m_cout});
         chk("zero", {63'd0, zero}, {63'd0, m_zero});
         if (m_run == 0) chk("sum", {32'd0, sum}, {32'd0, m_sum});
      end
   end

   // One operation on the 4-lane DUT with latency/busy-length checks and
   // optional literal result expectations.
   task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        input logic sv, input bit lit, input logic [W-1:0] es,
                        input logic ec, input logic ez);
      int lat = 0;
      int nbusy = 0;
      @(negedge clk);
      start = 1'b1; a = av; b = bv; cin = cv; sub = sv;
      do begin
         @(negedge clk);
         start = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom);
         lat++;
         if (busy) nbusy++;
      end while (!done && lat < 20);
      chk("latency", 64'(lat), 64'(NB + 1));
      chk("busy_cycles", 64'(nbusy), 64'(NB));
      if (lit) begin
         chk("lit_sum", {32'd0, sum}, {32'd0, es});
         chk("lit_cout", {63'd0, cout}, {63'd0, ec});
         chk("lit_zero", {63'd0, zero}, {63'd0, ez});
      end
      sub = 1'b0;
   endtask

   task automatic do_op1(input logic [7:0] av, input logic [7:0] bv, input logic cv);
      int lat = 0;
      logic [8:0] e;
      e = {1'b0, av} + {1'b0, bv} + {8'd0, cv};
      @(negedge clk);
      start1 = 1'b1; a1 = av; b1 = bv; cin1 = cv;
      do begin
         @(negedge clk);
         start1 = 1'b0; a1 = 8'($urandom); b1 = 8'($urandom);
         lat++;
         if (lat == 1) chk("n1_busy", {63'd0, busy1}, 64'd1);
      end while (!done1 && lat < 10);
      chk("n1_latency", 64'(lat), 64'd2);
      chk("n1_sum", {56'd0, sum1}, {56'd0, e[7:0]});
      chk("n1_cout", {63'd0, cout1}, {63'd0, e[8]});
      chk("n1_zero", {63'd0, zero1}, {63'd0, (e[7:0] == 8'd0)});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_sum", {32'd0, sum}, 64'd0);
      chk("rst_cout", {63'd0, cout}, 64'd0);
      chk("rst_zero", {63'd0, zero}, 64'd0);
      #2 rst_n = 1'b1;
      cmp_en = 1'b1;

      // Basic add, full carry ripple
      do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
      do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1);
      do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1);

      // Start held through RUN with operands changing, then back-to-back
      @(negedge clk);
      start = 1'b1; a = 32'h1111_1111; b = 32'h2222_2222; cin = 1'b0;
      @(negedge clk);
      a = 32'h1234_5678;
      lat = 1;
      while (!done && lat < 20) begin @(negedge clk); lat++; end
      chk("held_latency", 64'(lat), 64'(NB + 1));
      chk("held_sum", {32'd0, sum}, 64'h3333_3333);
      a = 32'h10; b = 32'h20;
      @(negedge clk);
      chk("b2b_busy", {63'd0, busy}, 64'd1);
      start = 1'b0;
      lat = 1;
      while (!done && lat < 20) begin @(negedge clk); lat++; end
      chk("b2b_latency", 64'(lat), 64'(NB + 1));
      chk("b2b_sum", {32'd0, sum}, 64'h30);

      // Asynchronous reset after the 2nd RUN edge
      @(negedge clk);
      start = 1'b1; a = 32'h0101_0101; b = 32'h0101_0101; cin = 1'b0;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", {63'd0, busy}, 64'd0);
      chk("arst_done", {63'd0, done}, 64'd0);
      chk("arst_sum", {32'd0, sum}, 64'd0);
      chk("arst_cout", {63'd0, cout}, 64'd0);
      @(negedge clk); #2 rst_n = 1'b1;
      repeat (NB + 2) begin
         @(negedge clk);
         chk("arst_no_done", {63'd0, done}, 64'd0);
      end
      do_op(32'h7, 32'h8, 1'b0, 1'b0, 1'b1, 32'h0000_000F, 1'b0, 1'b0);

`ifdef CSKA_SEQ_SUB_EN
      do_op(32'h5, 32'h7, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      do_op(32'h7, 32'h5, 1'b1, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
      do_op(32'h9, 32'h9, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b1);
`endif

      // Single-lane instance
      do_op1(8'hC8, 8'h64, 1'b0);
      do_op1(8'hFF, 8'h00, 1'b1);
      for (int i = 0; i < 8; i++) do_op1(8'($urandom), 8'($urandom), 1'($urandom));

      // Randomized free-running stimulus with occasional async resets
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 3))
            0: a = '1;
            1: a = '0;
            default: a = $urandom;
         endcase
         b   = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
         cin = 1'($urandom);
`ifdef CSKA_SEQ_SUB_EN
         sub = 1'($urandom);
`endif
         if ($urandom_range(0, 99) == 0) begin
            #2 rst_n = 1'b0;
            @(negedge clk); #2 rst_n = 1'b1;
         end
      end
      start = 1'b0;
      repeat (NB + 3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
